// File: rtl/serial_bit_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_stream_gen
// Description : Parallel-to-serial word serialiser with valid/ready load,
//               hold/stall and a saturating completed-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_stream_gen #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int              c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [CNT_W-1:0]   c_wrd_one = CNT_W'(1);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  logic [0:0]         r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shreg, w_shreg_nxt;
  logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;
  logic [CNT_W-1:0]   r_words, w_words_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_head;

  // The head is the bit currently on x; shifting moves the next bit into it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_head    = r_shreg[WIDTH-1];
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_head    = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_words <= w_words_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_words_nxt = r_words;
    case (r_state)
      c_st_idle: begin
        if (load_valid) begin
          w_shreg_nxt = load_data;
          w_cnt_nxt   = c_cnt_top;
          w_state_nxt = c_st_shift;
        end
      end
      c_st_shift: begin
        if (!hold) begin
          if (r_cnt != '0) begin
            w_shreg_nxt = w_shifted;
            w_cnt_nxt   = r_cnt - c_cnt_one;
          end else begin
            if (r_words != '1) begin
              w_words_nxt = r_words + c_wrd_one;
            end
            // Reload on the final bit keeps the stream gap-free.
            if (load_valid) begin
              w_shreg_nxt = load_data;
              w_cnt_nxt   = c_cnt_top;
            end else begin
              w_shreg_nxt = '0;
              w_state_nxt = c_st_idle;
            end
          end
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  always_comb begin
    busy       = (r_state == c_st_shift);
    x          = busy & w_head;
    x_valid    = busy & ~hold;
    last       = busy & (r_cnt == '0) & ~hold;
    load_ready = rst & (busy ? last : 1'b1);
    words_sent = r_words;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_stream_gen.sv
`default_nettype none
// Self-checking bench for serial_bit_stream_gen: scoreboard of expected
// serial bits, plus directed checks of reset, hold, counter and handshake.
module tb_serial_bit_stream_gen;

  logic       clk;
  logic       rst;
  logic       lv_a, lr_a, hold_a, x_a, xv_a, last_a, busy_a;
  logic [7:0] ld_a;
  logic [1:0] ws_a;
  logic       lv_b, lr_b, hold_b, x_b, xv_b, last_b, busy_b;
  logic [3:0] ld_b;
  logic [7:0] ws_b;

  int n_chk;
  int n_err;
  int run_a;
  int max_run_a;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  serial_bit_stream_gen #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a),
    .load_data(ld_a), .hold(hold_a), .x(x_a), .x_valid(xv_a),
    .last(last_a), .busy(busy_a), .words_sent(ws_a)
  );

  serial_bit_stream_gen #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b),
    .load_data(ld_b), .hold(hold_b), .x(x_b), .x_valid(xv_b),
    .last(last_b), .busy(busy_b), .words_sent(ws_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: every x_valid cycle consumes one expected {bit,last}.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst) begin
      if (xv_a) begin
        run_a++;
        if (run_a > max_run_a) max_run_a = run_a;
        if (q_a.size() == 0) begin
          check("a_unexpected_bit", 1, 0);
        end else begin
          e = q_a.pop_front();
          check("a_x", x_a, e[1]);
          check("a_last", last_a, e[0]);
        end
      end else begin
        run_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst && xv_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_bit", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("b_x", x_b, e[1]);
        check("b_last", last_b, e[0]);
      end
    end
  end

  task automatic push_a(input logic [7:0] d);
    for (int i = 0; i < 8; i++) q_a.push_back({d[7-i], (i == 7) ? 1'b1 : 1'b0});
  endtask

  // Present a word on A and wait (bounded) for the accepting edge; leaves
  // load_valid high so the caller can chain words back-to-back.
  task automatic send_a(input logic [7:0] d);
    logic r;
    int   n;
    lv_a = 1'b1;
    ld_a = d;
    push_a(d);
    n = 0;
    do begin
      r = lr_a;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 64);
    if (!r) check("a_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 64 && busy_a; i++) begin
      @(posedge clk);
      #1;
    end
    check("a_idle_timeout", busy_a, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; run_a = 0; max_run_a = 0;
    rst = 1'b0;
    lv_a = 1'b0; ld_a = '0; hold_a = 1'b0;
    lv_b = 1'b0; ld_b = '0; hold_b = 1'b0;

    // Reset state before any clock edge
    #3;
    check("rst_x", x_a, 0);
    check("rst_xv", xv_a, 0);
    check("rst_last", last_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ready", lr_a, 0);
    check("rst_ws", ws_a, 0);
    do_reset();
    check("idle_ready", lr_a, 1);

    // Single word, MSB first
    send_a(8'b1010_1011);
    lv_a = 1'b0;
    wait_idle_a();
    check("t1_ws", ws_a, 1);
    check("t1_ready", lr_a, 1);

    // Back-to-back words with no bubble
    do_reset();
    max_run_a = 0;
    send_a(8'hA5);
    send_a(8'h3C);
    lv_a = 1'b0;
    wait_idle_a();
    check("t2_ws", ws_a, 2);
    check("t2_gapless_run", max_run_a, 16);

    // Hold during the third bit
    do_reset();
    send_a(8'hF0);
    lv_a = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    hold_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_x", x_a, 1);
      check("hold_xv", xv_a, 0);
      check("hold_last", last_a, 0);
      check("hold_ready", lr_a, 0);
      @(posedge clk);
      #1;
    end
    hold_a = 1'b0;
    wait_idle_a();
    check("t3_ws", ws_a, 1);

    // Asynchronous reset mid-word
    do_reset();
    send_a(8'hFF);
    lv_a = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_x", x_a, 0);
    check("arst_xv", xv_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_ready", lr_a, 0);
    q_a.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    check("arst_ws", ws_a, 0);
    @(posedge clk);
    #1;
    send_a(8'h96);
    lv_a = 1'b0;
    wait_idle_a();
    check("t4_ws", ws_a, 1);

    // Saturating word counter (CNT_W=2)
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_a(8'h11 * k[7:0] + 8'h0F);
      lv_a = 1'b0;
      wait_idle_a();
      check("sat_ws", ws_a, (k + 1 > 3) ? 3 : k + 1);
    end

    // Detector feed pattern 0,0,0,1,0,1,0,1
    do_reset();
    send_a(8'b0001_0101);
    lv_a = 1'b0;
    wait_idle_a();

    // LSB-first, 4-bit instance: 4'b0011 -> 1,1,0,0
    lv_b = 1'b1;
    ld_b = 4'b0011;
    q_b.push_back(2'b10);
    q_b.push_back(2'b10);
    q_b.push_back(2'b00);
    q_b.push_back(2'b01);
    check("b_ready", lr_b, 1);
    @(posedge clk);
    #1;
    lv_b = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("b_ws", ws_b, 1);
    check("b_busy", busy_b, 0);

    repeat (3) @(posedge clk);
    #1;
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
